// File: rtl/mul_add_arb_pkg.sv
// Shared constants and helpers for the mul_add_arb slice.
// Grant counter width and requester-id width calculation.
package mul_add_arb_pkg;

  localparam int CntW = 16;

  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mul_add_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after ptr.
// Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int NumReq = 4,
  parameter int IdW    = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    gnt_idx_o,
  output logic              any_o
);

  logic found;

  // k is the distance from ptr; the closest valid requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      for (int j = 0; j < NumReq; j++) begin
        if (!found && req_i[j] &&
            ((j - int'(ptr_i) + NumReq) % NumReq == k)) begin
          found     = 1'b1;
          gnt_o[j]  = 1'b1;
          gnt_idx_o = IdW'(j);
        end
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mul_add_arb.sv
// Round-robin shared multiply-add (P = X*Y + A) with a 2-stage pipeline.
// Define MUL_ADD_ARB_STATS_EN for per-requester saturating grant counters.
module mul_add_arb
  import mul_add_arb_pkg::*;
#(
  parameter int  NumReq = 4,
  parameter int  WidthX = 8,
  parameter int  WidthY = 8,
  parameter int  WidthA = 20,
  parameter int  Speed  = 1,
  localparam int IdW    = id_width(NumReq)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic [NumReq*WidthX-1:0] req_x_i,
  input  logic [NumReq*WidthY-1:0] req_y_i,
  input  logic [NumReq*WidthA-1:0] req_a_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WidthA-1:0]        rsp_p_o,
  output logic [IdW-1:0]           rsp_id_o,
  output logic                     busy_o
`ifdef MUL_ADD_ARB_STATS_EN
  ,
  input  logic                     stats_clr_i,
  output logic [NumReq*CntW-1:0]   grant_cnt_o
`endif
);

  localparam int WidthP = WidthX + WidthY;
  localparam int Lv     = $clog2(WidthA);

  if (WidthX > WidthY) begin : g_bad_wx
    $error("mul_add_arb: WidthX must not exceed WidthY");
  end
  if (WidthA < WidthP) begin : g_bad_wa
    $error("mul_add_arb: WidthA must be >= WidthX+WidthY");
  end
  if (NumReq < 2) begin : g_bad_nr
    $error("mul_add_arb: NumReq must be >= 2");
  end

  logic [NumReq-1:0] gnt;
  logic [IdW-1:0]    gnt_idx;
  logic              any_req;
  logic              s2_adv;
  logic              s1_free;
  logic              accept;

  logic [WidthX-1:0] x_sel;
  logic [WidthY-1:0] y_sel;
  logic [WidthA-1:0] a_sel;

  logic [IdW-1:0]    ptr_q, ptr_d;
  logic              s1_valid_q, s1_valid_d;
  logic [WidthX-1:0] s1_x_q, s1_x_d;
  logic [WidthY-1:0] s1_y_q, s1_y_d;
  logic [WidthA-1:0] s1_a_q, s1_a_d;
  logic [IdW-1:0]    s1_id_q, s1_id_d;
  logic              s2_valid_q, s2_valid_d;
  logic [WidthA-1:0] s2_p_q, s2_p_d;
  logic [IdW-1:0]    s2_id_q, s2_id_d;

  logic [WidthP-1:0] prod;
  logic [WidthA-1:0] add_a;
  logic [WidthA-1:0] add_b;
  logic [WidthA-1:0] sum;

  rr_arbiter #(
    .NumReq (NumReq),
    .IdW    (IdW)
  ) u_arb (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_req)
  );

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    a_sel = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt[i]) begin
        x_sel = req_x_i[i*WidthX +: WidthX];
        y_sel = req_y_i[i*WidthY +: WidthY];
        a_sel = req_a_i[i*WidthA +: WidthA];
      end
    end
  end

  // Datapath: product is exact; the final add wraps mod 2^WidthA.
  assign prod  = {{WidthY{1'b0}}, s1_x_q} * {{WidthX{1'b0}}, s1_y_q};
  assign add_a = WidthA'(prod);
  assign add_b = s1_a_q;

  if (Speed == 0) begin : g_ripple
    always_comb begin
      logic c;
      c   = 1'b0;
      sum = '0;
      for (int i = 0; i < WidthA; i++) begin
        sum[i] = add_a[i] ^ add_b[i] ^ c;
        c = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
      end
    end
  end else if (Speed == 1) begin : g_bk
    logic [WidthA-1:0] gg, pp;
    always_comb begin
      int k;
      k  = 0;
      gg = add_a & add_b;
      pp = add_a ^ add_b;
      for (int l = 0; l < Lv; l++) begin
        for (int i = 0; i < WidthA; i++) begin
          if ((i + 1) % (1 << (l + 1)) == 0) begin
            k     = i - (1 << l);
            gg[i] = gg[i] | (pp[i] & gg[k]);
            pp[i] = pp[i] & pp[k];
          end
        end
      end
      // Down-sweep fills the prefixes the up-sweep tree skipped.
      for (int l = Lv - 2; l >= 0; l--) begin
        for (int i = 0; i < WidthA; i++) begin
          if (((i + 1) % (1 << (l + 1)) == (1 << l)) &&
              (i >= (1 << (l + 1)))) begin
            k     = i - (1 << l);
            gg[i] = gg[i] | (pp[i] & gg[k]);
            pp[i] = pp[i] & pp[k];
          end
        end
      end
      sum = (add_a ^ add_b) ^ {gg[WidthA-2:0], 1'b0};
    end
  end else begin : g_sk
    logic [WidthA-1:0] gg, pp;
    always_comb begin
      int k;
      k  = 0;
      gg = add_a & add_b;
      pp = add_a ^ add_b;
      for (int l = 0; l < Lv; l++) begin
        for (int i = 0; i < WidthA; i++) begin
          if (((i >> l) & 1) == 1) begin
            k     = ((i >> l) << l) - 1;
            gg[i] = gg[i] | (pp[i] & gg[k]);
            pp[i] = pp[i] & pp[k];
          end
        end
      end
      sum = (add_a ^ add_b) ^ {gg[WidthA-2:0], 1'b0};
    end
  end

  always_comb begin
    s2_adv      = s1_valid_q & (~s2_valid_q | rsp_ready_i);
    s1_free     = ~s1_valid_q | s2_adv;
    accept      = any_req & s1_free;
    req_ready_o = s1_free ? gnt : '0;

    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_idx == IdW'(NumReq - 1)) ? '0
                                            : gnt_idx + IdW'(1);
    end

    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_a_d     = s1_a_q;
    s1_id_d    = s1_id_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_x_d     = x_sel;
      s1_y_d     = y_sel;
      s1_a_d     = a_sel;
      s1_id_d    = gnt_idx;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_p_d     = s2_p_q;
    s2_id_d    = s2_id_q;
    if (s2_adv) begin
      s2_valid_d = 1'b1;
      s2_p_d     = sum;
      s2_id_d    = s1_id_q;
    end else if (s2_valid_q & rsp_ready_i) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_a_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
      s2_id_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_a_q     <= s1_a_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_p_q     <= s2_p_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign rsp_valid_o = s2_valid_q;
  assign rsp_p_o     = s2_p_q;
  assign rsp_id_o    = s2_id_q;
  assign busy_o      = s1_valid_q | s2_valid_q;

`ifdef MUL_ADD_ARB_STATS_EN
  logic [CntW-1:0] cnt_q [NumReq];
  logic [CntW-1:0] cnt_d [NumReq];

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr_i) begin
        cnt_d[i] = '0;
      end else if (accept && gnt[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumReq; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      grant_cnt_o[i*CntW +: CntW] = cnt_q[i];
    end
  end
`endif

endmodule
